// File: rtl/mic_pkg.sv
// Shared types and 50 MHz defaults for the microphone front-end.
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GROUP,
        REPORT
    } clap_state_t;

    localparam int DEBOUNCE_DEF  = 50000;
    localparam int WINDOW_DEF    = 25000000;
    localparam int MAX_CLAPS_DEF = 3;
    localparam int COUNT_W       = 3;

endpackage

// File: rtl/mic_debounce.sv
// Two-flop synchroniser plus stability counter; reusable for push buttons.
module mic_debounce
    import mic_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample agreeing with the current level restarts the stability run
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mic_conditioner.sv
// Microphone front-end: debounce, onset pulse and clap grouping.
// Define MIC_COND_MULTICLAP_EN to build the windowed grouping FSM; otherwise each onset reports one clap.
module mic_conditioner
    import mic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int WINDOW_CYCLES   = WINDOW_DEF,
    parameter int MAX_CLAPS       = MAX_CLAPS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mic,
    input  logic               enable,
    output logic               sound_level,
    output logic               sound_pulse,
    output logic               clap_pulse,
    output logic [COUNT_W-1:0] clap_count,
    output logic               busy
);

    logic deb_level;
    logic rise;

    mic_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (mic),
        .level (deb_level)
    );

    // The FSM acts on the same-cycle onset so its state lines up with the registered pulse
    assign rise = deb_level & ~sound_level & enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sound_level <= 1'b0;
            sound_pulse <= 1'b0;
        end else begin
            sound_level <= deb_level;
            sound_pulse <= rise;
        end
    end

`ifdef MIC_COND_MULTICLAP_EN
    localparam int TW = $clog2(WINDOW_CYCLES + 1);

    clap_state_t        state, state_nxt;
    logic [COUNT_W-1:0] count, count_nxt;
    logic [TW-1:0]      timer, timer_nxt;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = GROUP;
                    count_nxt = COUNT_W'(1);
                    timer_nxt = '0;
                end
            end
            GROUP: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    timer_nxt = '0;
                end else if (rise) begin
                    // An onset on the terminal cycle wins over the report
                    count_nxt = (count >= COUNT_W'(MAX_CLAPS)) ? COUNT_W'(MAX_CLAPS)
                                                               : count + COUNT_W'(1);
                    timer_nxt = '0;
                end else if (timer == TW'(WINDOW_CYCLES - 1)) begin
                    state_nxt = REPORT;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            REPORT: begin
                state_nxt = IDLE;
                count_nxt = '0;
                timer_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            timer      <= '0;
            clap_pulse <= 1'b0;
            clap_count <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            timer      <= timer_nxt;
            clap_pulse <= (state_nxt == REPORT);
            busy       <= (state_nxt != IDLE);
            if (state_nxt == REPORT) clap_count <= count;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clap_pulse <= 1'b0;
            clap_count <= '0;
        end else begin
            clap_pulse <= sound_pulse;
            if (sound_pulse) clap_count <= COUNT_W'(1);
        end
    end

    assign busy = 1'b0;
`endif

endmodule

// File: doc/mic_conditioner.md
# mic_conditioner

Front-end for the digital microphone (sound-sensor comparator output). It synchronises and debounces the raw input, turns each clean sound onset into a one-cycle event, and groups events arriving close together into a clap count. It sits directly upstream of the microphone/buzzer responder, which takes `sound_pulse` as its wake trigger instead of sampling the raw pin.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before the clean level changes (1 ms at 50 MHz); must be ≥ 1.
- `WINDOW_CYCLES`, default 25000000: maximum gap between claps of one group (0.5 s at 50 MHz); must be ≥ 2.
- `MAX_CLAPS`, default 3: saturation value of the clap count; range 1..7.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `mic`  in  1: raw comparator output, asynchronous, active-high.
- `enable`  in  1: accept events when high; supplied by the pet state logic.
- `sound_level`  out  1: debounced microphone level.
- `sound_pulse`  out  1: one-cycle pulse on each accepted rising edge of `sound_level`.
- `clap_pulse`  out  1: one-cycle pulse when a clap group closes.
- `clap_count`  out  3: number of claps in the closed group; valid while `clap_pulse` is high and held until the next report.
- `busy`  out  1: high while a group is open.

## Operation
- Reset values: `sound_level`=0, `sound_pulse`=0, `clap_pulse`=0, `clap_count`=0, `busy`=0. The synchroniser flops clear, the debounce counter clears, and the FSM enters IDLE.
- Synchroniser: two flops on `mic`. Only the second flop's output is used downstream.
- Debounce: the counter resets whenever the synchronised input equals `sound_level`. Otherwise it increments. When the count reaches `DEBOUNCE_CYCLES`-1, `sound_level` takes the new value and the counter clears.
- Edge detection: `sound_pulse` = rising edge of `sound_level` AND `enable`. Falling edges produce no event.
- FSM states:
  - IDLE. On `sound_pulse`: count=1, window timer=0, go to GROUP.
  - GROUP. On `sound_pulse`: count = min(count+1, `MAX_CLAPS`) and timer=0. Otherwise the timer increments. When timer = `WINDOW_CYCLES`-1, go to REPORT.
  - REPORT. Lasts one cycle: `clap_pulse`=1, `clap_count` = count. Always returns to IDLE. A `sound_pulse` arriving during REPORT is dropped.
- `busy` is high in GROUP and REPORT.
- Simultaneous events: a `sound_pulse` in the same cycle the timer reaches its terminal value is counted, the timer restarts, and no report occurs.
- `enable` low in GROUP aborts the group: next state is IDLE, count clears, and no `clap_pulse` is issued. The debouncer keeps running regardless of `enable`.
- Counter widths: $clog2(param+1) bits. The timer saturates and never wraps.
- Reset asserted mid-group: all state clears immediately and no report is issued.

## Timing
- `mic` rises and stays high: `sound_level` and `sound_pulse` rise exactly `DEBOUNCE_CYCLES`+2 rising edges after the edge that first samples `mic` high. `sound_pulse` is high for one cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) produce no change.
- Last `sound_pulse` of a group to `clap_pulse`: exactly `WINDOW_CYCLES` cycles.
- All outputs are registered.

## Configuration
- `MIC_COND_MULTICLAP_EN` defined: grouping FSM as described above.
- `MIC_COND_MULTICLAP_EN` undefined:
  - no window timer and no FSM;
  - `clap_pulse` = `sound_pulse` delayed by one register, with `clap_count`=1;
  - `busy` tied to 0.

## Structure
- Package `mic_pkg` holds:
  - the FSM state enum (IDLE, GROUP, REPORT);
  - the default constants for debounce, window and max-claps at 50 MHz;
  - the count width constant (3).
- Sub-module `mic_debounce` holds the synchroniser plus the debounce counter, and outputs `sound_level`. It is reusable for the push buttons.
- The top module holds the edge detector, FSM and window timer.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4, `WINDOW_CYCLES`=20, `MAX_CLAPS`=3, `enable`=1 unless stated.
- Glitch rejection: `mic` high for 3 cycles, then low -> `sound_level` stays 0 and there are no pulses.
- Single clap: `mic` high for 10 cycles -> `sound_pulse` 6 edges after first sample, then `clap_pulse` 20 cycles later with `clap_count`=1.
- Saturation: 5 claps, each 8 cycles apart -> one `clap_pulse`, `clap_count`=3, 20 cycles after the 5th `sound_pulse`.
- Boundary: 2nd `sound_pulse` lands on timer=19 -> counted, no report, final `clap_count`=2.
- Abort and reset: `enable` dropped mid-group -> no `clap_pulse` and `busy`=0 next cycle. `rst` pulsed mid-group -> all outputs 0 immediately.
- Macro off: single clap -> `clap_pulse` one cycle after `sound_pulse`, `clap_count`=1, `busy`=0.
